div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multicycle signed divider (MIPS DIV) acting as the responder to the control unit's start request.
- Takes rs/rt operands on a start pulse. Runs one restoring iteration per clock. Returns quotient (LO) and remainder (HI) with a one-cycle done pulse.
- Outputs feed the DIV side of the HI/LO select mux.
- Flags divide-by-zero so the control unit can take its exception path.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  rs value, two's complement
- divisor  in  WIDTH  rt value, two's complement
- lo  out  WIDTH  quotient, registered
- hi  out  WIDTH  remainder, registered
- busy  out  1  division in progress
- done  out  1  one-cycle pulse: hi/lo valid/updated
- div_zero  out  1  one-cycle pulse: divisor was zero

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset low clears everything immediately, independent of clk).
- Reset values: lo=0, hi=0, busy=0, done=0, div_zero=0; state=IDLE; internal counter and work registers = 0.
- States: IDLE, RUN, FIX.
- IDLE, start=1, divisor!=0, at edge E0:
  - latch |dividend| into quotient shift register; latch |divisor|.
  - record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - clear partial remainder and counter; busy<=1; go to RUN.
- IDLE, start=1, divisor==0, at E0:
  - div_zero<=1 and done<=1 for exactly one cycle.
  - busy stays 0; hi/lo keep their previous values; stay in IDLE.
- RUN (edges E1..E32): one restoring step per edge.
  - rem = {rem[W-2:0], q[W-1]}; q shifts left.
  - if rem >= |divisor|: rem -= |divisor| and the new q LSB = 1; else the LSB = 0.
  - The comparison and subtraction use W+1 bits; no truncation.
  - The counter increments each step; after step WIDTH go to FIX.
- FIX (edge E33):
  - lo <= sign_q ? -q : q; hi <= sign_r ? -rem : rem.
  - done<=1 and busy<=0 at the same edge; return to IDLE.
- Latency: start at E0 -> results and done visible after E33 (WIDTH+1 edges). done is cleared at E34.
- Rounding: the quotient truncates toward zero; the remainder takes the sign of the dividend (|hi| < |divisor|).
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag raised (matches the unsigned-magnitude result).
- start while busy: ignored; in-flight operands are unaffected.
- start on the cycle done is high: accepted normally (state is IDLE).
- Operand inputs are don't-care except in IDLE with start=1.
- Reset asserted mid-operation: immediate return to reset values. No done pulse; hi/lo cleared.
- done and div_zero never pulse for more than one cycle. div_zero is never high without done.

Decomposition:
- Shared package div_pkg holds:
  - state enum/localparams (IDLE=2'd0, RUN=2'd1, FIX=2'd2)
  - DIV_WIDTH=32
  - the counter width constant $clog2(DIV_WIDTH)+1
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, q, |divisor|. Outputs: next rem, next q.
  - The FSM, sign handling and output registers stay in div_unit.

Test Plan:
- dividend=100, divisor=7, start at E0 -> busy 1 over E0..E33, done only after E33, lo=14, hi=2, div_zero=0.
- dividend=-100 (0xFFFFFF9C), divisor=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); also 5 / -3 -> lo=0xFFFFFFFF (-1), hi=2.
- Preload hi/lo from a prior op (14/2); dividend=7, divisor=0 -> div_zero=1 and done=1 for one cycle after E0, busy stays 0, hi=2, lo=14 unchanged.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0 after E33, div_zero=0; also 0/5 -> lo=0, hi=0.
- Start 100/7 at E0, pulse start again with 9/3 at E10 -> ignored, result lo=14, hi=2 at E33. Then start 9/3 in the done cycle -> lo=3, hi=0 after 33 more edges.
- Start 100/7, drive reset low between E10 and E11 -> outputs 0 immediately, no done pulse. Release reset, start 20/6 -> lo=3, hi=2 after E33.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider.
//   state_t     : divider FSM state encoding
//   DIV_WIDTH   : default operand/result width
//   DIV_CNT_W   : iteration counter width, wide enough to hold DIV_WIDTH
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Ports:
//   rem_i  : partial remainder before the step
//   q_i    : quotient shift register before the step (MSB feeds the remainder)
//   dvsr_i : divisor magnitude
//   rem_o  : partial remainder after the step
//   q_o    : quotient shift register after the step (new LSB = quotient bit)
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] trial;
  logic           ge;

  always_comb begin
    trial = {rem_i, q_i[WIDTH-1]};
    ge    = (trial >= {1'b0, dvsr_i});
    q_o   = {q_i[WIDTH-2:0], ge};
    // When ge holds, the exact difference is below dvsr_i and so fits in
    // WIDTH bits; the modulo-2^WIDTH subtraction of the low bits is exact.
    if (ge) begin
      rem_o = trial[WIDTH-1:0] - dvsr_i;
    end else begin
      rem_o = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (MIPS DIV). One restoring step per clock on the
// operand magnitudes, then a sign fix-up cycle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; a zero divisor flags div_zero right here
//   RUN   | WIDTH restoring iterations, one per clock
//   FIX   | apply signs, register lo/hi, pulse done
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : request, sampled only in IDLE
//   dividend : rs operand (two's complement)
//   divisor  : rt operand (two's complement)
//   lo       : quotient, truncated toward zero
//   hi       : remainder, sign of dividend
//   busy     : division in progress
//   done     : one-cycle pulse, lo/hi updated (or div-by-zero reported)
//   div_zero : one-cycle pulse alongside done when the divisor was zero
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] step_rem, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .q_i    (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      sgn_quo_q  <= 1'b0;
      sgn_rem_q  <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      sgn_quo_q  <= sgn_quo_d;
      sgn_rem_q  <= sgn_rem_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    sgn_quo_d  = sgn_quo_q;
    sgn_rem_d  = sgn_rem_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            // Negating the most negative value wraps to itself, which is
            // still the correct unsigned magnitude.
            quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d    = divisor[WIDTH-1]  ? -divisor  : divisor;
            sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_rem_d = dividend[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sgn_quo_q ? -quo_q : quo_q;
        hi_d    = sgn_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lo       = lo_q;
  assign hi       = hi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operands compared against plain signed 64-bit arithmetic.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] exp_lo = '0;
  logic [W-1:0] exp_hi = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .lo       (lo),
    .hi       (hi),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV semantics via signed 64-bit arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    logic [63:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    uq = 64'(lq);
    ur = 64'(lr);
    q  = uq[W-1:0];
    r  = ur[W-1:0];
  endtask

  // Called at a negative edge. Issues one request; inj >= 0 re-pulses start
  // with 9/3 at that cycle count to confirm it is ignored while busy.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    int cyc;
    logic [W-1:0] mq, mr;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    if (b == '0) begin
      check({tag, "/dz_done"}, W'(done), W'(1));
      check({tag, "/dz_flag"}, W'(div_zero), W'(1));
      check({tag, "/dz_busy"}, W'(busy), W'(0));
      check({tag, "/dz_lo"}, lo, exp_lo);
      check({tag, "/dz_hi"}, hi, exp_hi);
      @(negedge clk);
      check({tag, "/dz_done_clr"}, W'(done | div_zero), W'(0));
      return;
    end
    model(a, b, mq, mr);
    check({tag, "/busy"}, W'(busy), W'(1));
    cyc = 0;
    while (!done && cyc < 40) begin
      if (!busy) check({tag, "/busy_drop"}, W'(busy), W'(1));
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_lo = mq;
    exp_hi = mr;
    check({tag, "/latency"}, W'(cyc), W'(33));
    check({tag, "/lo"}, lo, exp_lo);
    check({tag, "/hi"}, hi, exp_hi);
    check({tag, "/div_zero"}, W'(div_zero), W'(0));
    check({tag, "/busy_end"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int seen_done;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst/lo", lo, '0);
    check("rst/hi", hi, '0);
    check("rst/flags", W'({busy, done, div_zero}), W'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("p100_7", 32'd100, 32'd7, -1);
    @(negedge clk);
    check("p100_7/done_clr", W'(done), W'(0));
    run_op("n100_7", 32'hFFFFFF9C, 32'd7, -1);
    run_op("p5_n3", 32'd5, 32'hFFFFFFFD, -1);
    run_op("pre14_2", 32'd100, 32'd7, -1);
    @(negedge clk);
    run_op("dz", 32'd7, 32'd0, -1);
    run_op("ovf", 32'h80000000, 32'hFFFFFFFF, -1);
    run_op("zero5", 32'd0, 32'd5, -1);

    // Start again while busy is ignored; then start in the done cycle.
    run_op("ign", 32'd100, 32'd7, 9);
    run_op("done_cyc", 32'd9, 32'd3, -1);

    // Reset mid-operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mrst/lo", lo, '0);
    check("mrst/hi", hi, '0);
    check("mrst/flags", W'({busy, done, div_zero}), W'(0));
    exp_lo = '0;
    exp_hi = '0;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("mrst/no_done", W'(seen_done), W'(0));
    reset = 1'b1;
    @(negedge clk);
    run_op("p20_6", 32'd20, 32'd6, -1);

    // Randomized operands, with a mix of small and full-range values.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = W'($urandom_range(0, 9));
        1: rb = -W'($urandom_range(1, 9));
        2: rb = $urandom() >> $urandom_range(0, 31);
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      @(negedge clk);
      run_op("rand", ra, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
